// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
// Decode stage of the 5-stage core: register file with write-through bypass,
// immediate extension, load-use hazard detection and the D->E pipeline
// register carrying a valid bit. Register count is configurable (RV32I/RV32E).
module decode_stage_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int A0_IDX     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] PC_F_i,
    input  logic [DATA_WIDTH-1:0] PC_Plus4_F_i,
    input  logic                  validD_i,
    input  logic [2:0]            ImmSrc_i,
    input  logic                  is_load_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [4:0]            RdW_i,
    input  logic [DATA_WIDTH-1:0] WD3_i,
    input  logic                  WE3_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] RD1E_o,
    output logic [DATA_WIDTH-1:0] RD2E_o,
    output logic [DATA_WIDTH-1:0] ImmExtE_o,
    output logic [DATA_WIDTH-1:0] PCE_o,
    output logic [DATA_WIDTH-1:0] PC_Plus4E_o,
    output logic [4:0]            RdE_o,
    output logic [4:0]            Rs1E_o,
    output logic [4:0]            Rs2E_o,
    output logic                  validE_o,
    output logic [DATA_WIDTH-1:0] a0_o
);

    localparam int         IDX_W = $clog2(NUM_REGS);
    localparam logic [5:0] NREG  = 6'(NUM_REGS);

    // Instruction fields
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];
    assign rd  = instr_i[11:7];

    // Opcode bits are consumed by the control unit, not here.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_en;

    // One write strobe per register; x0 never takes a write and indices
    // beyond NUM_REGS never match any strobe, so such writes vanish.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_en
            if (gi == 0) begin : g_x0
                assign wr_en[gi] = 1'b0;
            end else begin : g_xn
                assign wr_en[gi] = WE3_i && (RdW_i == 5'(gi));
            end
        end
    endgenerate

    // Register array: cleared on reset, written on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= WD3_i;
                end
            end
        end
    end

    // Read with x0/out-of-range -> 0, and same-cycle writeback bypass so the
    // value being written this cycle is seen by the instruction in D.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] idx);
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (idx != 5'd0 && {1'b0, idx} < NREG) begin
            if (WE3_i && RdW_i == idx) begin
                val = WD3_i;
            end else begin
                val = regs[idx[IDX_W-1:0]];
            end
        end
        return val;
    endfunction

    logic [DATA_WIDTH-1:0] rd1_d;
    logic [DATA_WIDTH-1:0] rd2_d;

    // Both read ports of the register file
    always_comb begin
        rd1_d = read_port(rs1);
        rd2_d = read_port(rs2);
    end

    // a0 tap straight from the array (no bypass), so a write shows up the
    // cycle after its edge.
    generate
        if (A0_IDX > 0 && A0_IDX < NUM_REGS) begin : g_a0
            assign a0_o = regs[A0_IDX];
        end else begin : g_a0_zero
            assign a0_o = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Immediate extension
    // ------------------------------------------------------------------
    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] imm_d;

    // Assemble the 32-bit immediate; every format carries its sign in bit 31.
    always_comb begin
        imm32 = 32'd0;
        case (ImmSrc_i)
            3'b000: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            3'b001: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            3'b010: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                             instr_i[30:25], instr_i[11:8], 1'b0};
            3'b011: imm32 = {instr_i[31:12], 12'd0};
            3'b100: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                             instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    // Widen to the datapath by replicating bit 31.
    generate
        if (DATA_WIDTH > 32) begin : g_imm_wide
            assign imm_d = {{(DATA_WIDTH-32){imm32[31]}}, imm32};
        end else begin : g_imm_32
            assign imm_d = imm32[DATA_WIDTH-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------
    logic load_e;
    logic haz;

    // A valid load in E whose destination is a source of the valid
    // instruction in D forces a one-cycle bubble. Flush overrides it.
    always_comb begin
        haz = validD_i && validE_o && load_e && (RdE_o != 5'd0) &&
              ((RdE_o == rs1) || (RdE_o == rs2));
        stall_o = haz && !flush_i;
    end

    // ------------------------------------------------------------------
    // D -> E pipeline register
    // ------------------------------------------------------------------
    logic bubble;
    assign bubble = flush_i || (!stall_i && haz);

    // E register: flush > external stall > hazard bubble > capture.
    // A bubble only needs valid/rd/load cleared; data follows D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RD1E_o      <= '0;
            RD2E_o      <= '0;
            ImmExtE_o   <= '0;
            PCE_o       <= '0;
            PC_Plus4E_o <= '0;
            RdE_o       <= '0;
            Rs1E_o      <= '0;
            Rs2E_o      <= '0;
            validE_o    <= 1'b0;
            load_e      <= 1'b0;
        end else if (bubble || !stall_i) begin
            RD1E_o      <= rd1_d;
            RD2E_o      <= rd2_d;
            ImmExtE_o   <= imm_d;
            PCE_o       <= PC_F_i;
            PC_Plus4E_o <= PC_Plus4_F_i;
            Rs1E_o      <= rs1;
            Rs2E_o      <= rs2;
            if (bubble) begin
                RdE_o    <= 5'd0;
                validE_o <= 1'b0;
                load_e   <= 1'b0;
            end else begin
                RdE_o    <= rd;
                validE_o <= validD_i;
                load_e   <= is_load_i && validD_i;
            end
        end
    end

endmodule
